// File: rtl/nfm_step_ctrl.sv
// -----------------------------------------------------------------------------
// nfm_step_ctrl
//
// Round sequencer placed directly in front of the nonlinear-function operand
// selector. It takes one fixed-point element per input handshake. It drives the
// selector step code and operand buses, and issues one compute-core round
// (root) or two rounds (softmax, gelu, silu). The round-A result is kept as the
// intermediate operand for round B. The final result is handed downstream with
// a valid/ready handshake. Only one element is in flight at a time.
//
// Mode encoding: 00 softmax, 01 gelu, 10 silu, 11 root.
// Step codes (sel_s): softmax 0 then 1, gelu/silu 2 then 3, root 4.
//
// Optional feature macro: NFM_STEP_STAT_EN
//   When defined, the parameter CNT_WIDTH and two status counter outputs are
//   added:
//     elem_cnt  : counts output handshakes.
//     stall_cnt : counts cycles spent in OUT while out_ready is low.
//   Both counters wrap naturally.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_load            load softmax max/sum (honoured only in IDLE)
//   cfg_max, cfg_sum    softmax row max / row sum
//   in_valid, in_ready  element handshake
//   in_mode             element mode
//   in_x                element value
//   in_u                round-B coefficient (gelu/silu)
//   sel_mode            selector mode
//   sel_s               selector step code
//   sel_in0             captured x
//   sel_in1             max register
//   sel_in2             intermediate register
//   sel_in3             sum register
//   sel_u               captured u
//   core_req            one-cycle round start pulse
//   core_ack, core_res  round completion and its result
//   out_valid           result handshake, valid side
//   out_ready           result handshake, ready side
//   out_data            final result
//   busy                high whenever the sequencer is not idle
//   elem_cnt            output handshake count (NFM_STEP_STAT_EN only)
//   stall_cnt           output stall cycle count (NFM_STEP_STAT_EN only)
// -----------------------------------------------------------------------------
module nfm_step_ctrl #(
  parameter int FIX_POINT_WIDTH = 16
`ifdef NFM_STEP_STAT_EN
  ,
  parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_load,
  input  logic [FIX_POINT_WIDTH-1:0] cfg_max,
  input  logic [FIX_POINT_WIDTH-1:0] cfg_sum,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_mode,
  input  logic [FIX_POINT_WIDTH-1:0] in_x,
  input  logic [FIX_POINT_WIDTH-1:0] in_u,
  output logic [1:0]                 sel_mode,
  output logic [2:0]                 sel_s,
  output logic [FIX_POINT_WIDTH-1:0] sel_in0,
  output logic [FIX_POINT_WIDTH-1:0] sel_in1,
  output logic [FIX_POINT_WIDTH-1:0] sel_in2,
  output logic [FIX_POINT_WIDTH-1:0] sel_in3,
  output logic [FIX_POINT_WIDTH-1:0] sel_u,
  output logic                       core_req,
  input  logic                       core_ack,
  input  logic [FIX_POINT_WIDTH-1:0] core_res,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIX_POINT_WIDTH-1:0] out_data,
  output logic                       busy
`ifdef NFM_STEP_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0]       elem_cnt,
  output logic [CNT_WIDTH-1:0]       stall_cnt
`endif
);

  localparam logic [1:0] MODE_SOFTMAX = 2'b00;
  localparam logic [1:0] MODE_ROOT    = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_A = 3'd1,
    WAIT_A  = 3'd2,
    ISSUE_B = 3'd3,
    WAIT_B  = 3'd4,
    OUT     = 3'd5
  } state_t;

  state_t state;

  // Step code for the first round of a given mode.
  function automatic logic [2:0] step_a(input logic [1:0] mode);
    case (mode)
      MODE_SOFTMAX: step_a = 3'd0;
      MODE_ROOT:    step_a = 3'd4;
      default:      step_a = 3'd2;
    endcase
  endfunction

  // Step code for the second round (root never reaches round B).
  function automatic logic [2:0] step_b(input logic [1:0] mode);
    step_b = (mode == MODE_SOFTMAX) ? 3'd1 : 3'd3;
  endfunction

  // The selector operand buses are the holding registers themselves, so they
  // only move on accept, cfg_load or a round-A result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      core_req  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sel_mode  <= 2'b00;
      sel_s     <= 3'd0;
      sel_in0   <= '0;
      sel_in1   <= '0;
      sel_in2   <= '0;
      sel_in3   <= '0;
      sel_u     <= '0;
    end else begin
      core_req <= 1'b0;

      // Config is written before the element latch takes effect, so a
      // cfg_load coinciding with an accept applies to that element.
      if (cfg_load && (state == IDLE)) begin
        sel_in1 <= cfg_max;
        sel_in3 <= cfg_sum;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            sel_mode <= in_mode;
            sel_in0  <= in_x;
            sel_u    <= in_u;
            sel_s    <= step_a(in_mode);
            core_req <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ISSUE_A;
          end
        end

        // Any ack seen while issuing belongs to no round and is dropped.
        ISSUE_A: state <= WAIT_A;

        WAIT_A: begin
          if (core_ack) begin
            sel_in2 <= core_res;
            if (sel_mode == MODE_ROOT) begin
              out_data  <= core_res;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              sel_s    <= step_b(sel_mode);
              core_req <= 1'b1;
              state    <= ISSUE_B;
            end
          end
        end

        ISSUE_B: state <= WAIT_B;

        WAIT_B: begin
          if (core_ack) begin
            out_data  <= core_res;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef NFM_STEP_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt  <= '0;
      stall_cnt <= '0;
    end else if (state == OUT) begin
      if (out_ready) begin
        elem_cnt <= elem_cnt + CNT_WIDTH'(1);
      end else begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_nfm_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nfm_step_ctrl
//
// Directed bench for nfm_step_ctrl. Inputs are driven and outputs sampled on
// the falling clock edge. A small core responder answers each core_req with an
// ack after a programmable number of extra cycles, popping results from a
// queue. A manual ack path drives stray or misplaced acks.
// -----------------------------------------------------------------------------
module tb_nfm_step_ctrl;

  localparam int FPW = 16;

  logic           clk;
  logic           rst_n;
  logic           cfg_load;
  logic [FPW-1:0] cfg_max;
  logic [FPW-1:0] cfg_sum;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_mode;
  logic [FPW-1:0] in_x;
  logic [FPW-1:0] in_u;
  logic [1:0]     sel_mode;
  logic [2:0]     sel_s;
  logic [FPW-1:0] sel_in0;
  logic [FPW-1:0] sel_in1;
  logic [FPW-1:0] sel_in2;
  logic [FPW-1:0] sel_in3;
  logic [FPW-1:0] sel_u;
  logic           core_req;
  logic           core_ack;
  logic [FPW-1:0] core_res;
  logic           out_valid;
  logic           out_ready;
  logic [FPW-1:0] out_data;
  logic           busy;
`ifdef NFM_STEP_STAT_EN
  logic [31:0]    elem_cnt;
  logic [31:0]    stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Core responder state.
  logic           auto_core;
  int             extra_wait;
  int             ack_cnt;
  logic           auto_ack;
  logic [FPW-1:0] auto_res;
  logic [FPW-1:0] res_q[$];
  logic           man_ack;
  logic [FPW-1:0] man_res;

  assign core_ack = auto_ack | man_ack;
  assign core_res = auto_ack ? auto_res : man_res;

  nfm_step_ctrl #(.FIX_POINT_WIDTH(FPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .cfg_max   (cfg_max),
    .cfg_sum   (cfg_sum),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_x      (in_x),
    .in_u      (in_u),
    .sel_mode  (sel_mode),
    .sel_s     (sel_s),
    .sel_in0   (sel_in0),
    .sel_in1   (sel_in1),
    .sel_in2   (sel_in2),
    .sel_in3   (sel_in3),
    .sel_u     (sel_u),
    .core_req  (core_req),
    .core_ack  (core_ack),
    .core_res  (core_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef NFM_STEP_STAT_EN
    ,
    .elem_cnt  (elem_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ack one cycle after the req is seen, plus extra_wait cycles.
  always @(negedge clk) begin
    auto_ack = 1'b0;
    if (auto_core) begin
      if (ack_cnt > 0) begin
        ack_cnt = ack_cnt - 1;
        if (ack_cnt == 0) begin
          auto_ack = 1'b1;
          auto_res = (res_q.size() > 0) ? res_q.pop_front() : 16'hDEAD;
        end
      end else if (core_req) begin
        ack_cnt = 1 + extra_wait;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present an element while IDLE; returns one falling edge after the accept.
  task automatic accept(input logic [1:0] m, input logic [FPW-1:0] x, input logic [FPW-1:0] u);
    in_mode  = m;
    in_x     = x;
    in_u     = u;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = core_req;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_out(input string tag);
    logic seen;
    seen = out_valid;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_max = '0; cfg_sum = '0;
    in_valid = 1'b0; in_mode = 2'b00; in_x = '0; in_u = '0;
    out_ready = 1'b0; man_ack = 1'b0; man_res = '0;
    auto_core = 1'b1; extra_wait = 0; ack_cnt = 0; auto_ack = 1'b0; auto_res = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset then idle
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel_s", sel_s, 0);
    chk("rst_core_req", core_req, 0);
    chk("rst_busy", busy, 0);

    // Softmax, core with two extra wait cycles
    cfg_max = 16'h0100; cfg_sum = 16'h0400; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    extra_wait = 2;
    res_q.push_back(16'h0055);
    res_q.push_back(16'h0015);
    accept(2'b00, 16'h0080, 16'h0000);
    chk("smx_req_a", core_req, 1);
    chk("smx_s_a", sel_s, 0);
    chk("smx_in0", sel_in0, 16'h0080);
    chk("smx_in1", sel_in1, 16'h0100);
    chk("smx_in3", sel_in3, 16'h0400);
    wait_req("smx_req_b_tmo");
    chk("smx_s_b", sel_s, 1);
    chk("smx_in2_b", sel_in2, 16'h0055);
    wait_out("smx_out_tmo");
    chk("smx_out", out_data, 16'h0015);
    drain();
    chk("smx_idle", busy, 0);

    // GELU with a zero-wait core: out_valid exactly 5 cycles after accept
    extra_wait = 0;
    res_q.push_back(16'h1111);
    res_q.push_back(16'h2222);
    accept(2'b01, 16'h8100, 16'h0033);
    chk("gelu_s_a", sel_s, 2);
    chk("gelu_mode", sel_mode, 2'b01);
    chk("gelu_in0", sel_in0, 16'h8100);
    chk("gelu_u", sel_u, 16'h0033);
    repeat (2) @(negedge clk);
    chk("gelu_req_b", core_req, 1);
    chk("gelu_s_b", sel_s, 3);
    @(negedge clk);
    chk("gelu_ov_t4", out_valid, 0);
    @(negedge clk);
    chk("gelu_ov_t5", out_valid, 1);
    chk("gelu_out", out_data, 16'h2222);
    drain();
    chk("gelu_ov_drop", out_valid, 0);
    chk("gelu_ready", in_ready, 1);

    // Root, single round, plus cfg_load in WAIT_A and 10-cycle output stall
    res_q.push_back(16'h0200);
    accept(2'b11, 16'h0400, 16'h0000);
    chk("root_req", core_req, 1);
    chk("root_s", sel_s, 4);
    @(negedge clk);
    chk("root_req_once", core_req, 0);
    chk("root_ov_t2", out_valid, 0);
    cfg_max = 16'hAAAA; cfg_sum = 16'hBBBB; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    chk("root_ov_t3", out_valid, 1);
    chk("root_out", out_data, 16'h0200);
    chk("busy_cfg_max", sel_in1, 16'h0100);
    chk("busy_cfg_sum", sel_in3, 16'h0400);
    in_valid = 1'b1; in_mode = 2'b00; in_x = 16'h7777;
    for (int i = 0; i < 10; i++) begin
      chk("stall_data", out_data, 16'h0200);
      chk("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stall_ov", out_valid, 1);
`ifdef NFM_STEP_STAT_EN
    chk("stall_cnt", stall_cnt, 10);
`endif
    drain();
    chk("stall_idle", busy, 0);
    chk("stall_x_kept", sel_in0, 16'h0400);
`ifdef NFM_STEP_STAT_EN
    chk("elem_cnt", elem_cnt, 3);
`endif

    // Stray acks, then reset asserted in WAIT_B
    auto_core = 1'b0;
    man_ack = 1'b1; man_res = 16'h1357;
    @(negedge clk);
    man_ack = 1'b0;
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_in2", sel_in2, 16'h0200);
    accept(2'b10, 16'h1234, 16'h0005);
    man_ack = 1'b1; man_res = 16'hBEEF;
    @(negedge clk);
    man_ack = 1'b0;
    chk("same_cyc_req", core_req, 0);
    chk("same_cyc_busy", busy, 1);
    chk("same_cyc_in2", sel_in2, 16'h0200);
    @(negedge clk);
    chk("silu_s_a", sel_s, 2);
    man_ack = 1'b1; man_res = 16'h0777;
    @(negedge clk);
    man_ack = 1'b0;
    chk("silu_req_b", core_req, 1);
    chk("silu_s_b", sel_s, 3);
    chk("silu_in2", sel_in2, 16'h0777);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_ov", out_valid, 0);
    chk("arst_s", sel_s, 0);
    chk("arst_in2", sel_in2, 0);
    chk("arst_in1", sel_in1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_ack = 1'b1; man_res = 16'h9999;
    @(negedge clk);
    man_ack = 1'b0;
    chk("late_ack_busy", busy, 0);
    chk("late_ack_ov", out_valid, 0);
    chk("late_ack_out", out_data, 0);
    chk("late_ack_in2", sel_in2, 0);

    // cfg_load on the same cycle as an accept applies to that element
    auto_core = 1'b1;
    extra_wait = 0;
    res_q.push_back(16'h0A0A);
    res_q.push_back(16'h0B0B);
    cfg_max = 16'h0111; cfg_sum = 16'h0222; cfg_load = 1'b1;
    accept(2'b00, 16'h0005, 16'h0000);
    chk("cfg_acc_max", sel_in1, 16'h0111);
    chk("cfg_acc_sum", sel_in3, 16'h0222);
    wait_out("cfg_acc_tmo");
    chk("cfg_acc_out", out_data, 16'h0B0B);
    drain();
    chk("cfg_acc_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
